// File: rtl/uart_arbiter_pkg.sv
// Shared types and constants for the UART ownership arbiter.
// Holds the core-index width, the default inactivity timeout and the FSM encoding.
package uart_arbiter_pkg;

    localparam int CPU_NUM_W        = 2;
    localparam int N_CPU            = 4;
    localparam int UART_ARB_TIMEOUT = 65535;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SWITCH = 2'd1,
        ST_GRANT  = 2'd2,
        ST_DRAIN  = 2'd3
    } arb_state_e;

    function automatic logic [N_CPU-1:0] idx_to_onehot(input logic [CPU_NUM_W-1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/uart_arbiter_chk.sv
// Invariant checker for the arbiter outputs.
// The grant vector must be one-hot or zero and always agree with the mux select index.
module uart_arbiter_chk
    import uart_arbiter_pkg::*;
(
    input logic                 clk,
    input logic                 rst_n,
    input logic [N_CPU-1:0]     cpu_grant,
    input logic [CPU_NUM_W-1:0] cpu_uart_num
);

    a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(cpu_grant));

    a_grant_matches_num: assert property (@(posedge clk) disable iff (!rst_n)
        (cpu_grant != 4'b0000) |-> (cpu_grant == idx_to_onehot(cpu_uart_num)));

endmodule

// File: rtl/uart_arbiter_rr_pick4.sv
// Combinational 4-way round-robin picker.
// Returns the first requester found scanning ptr, ptr+1, ... (mod 4).
module rr_pick4
    import uart_arbiter_pkg::*;
(
    input  logic [N_CPU-1:0]     req_i,
    input  logic [CPU_NUM_W-1:0] ptr_i,
    output logic [CPU_NUM_W-1:0] idx_o,
    output logic                 any_o
);

    logic [2*N_CPU-1:0]   rot_s;
    logic [CPU_NUM_W-1:0] ofs_s;

    // Rotate so the pointer position lands at bit 0, then pick the lowest set bit.
    always_comb begin
        rot_s = {req_i, req_i} >> ptr_i;
        if (rot_s[0]) begin
            ofs_s = 2'd0;
        end else if (rot_s[1]) begin
            ofs_s = 2'd1;
        end else if (rot_s[2]) begin
            ofs_s = 2'd2;
        end else begin
            ofs_s = 2'd3;
        end
        idx_o = ptr_i + ofs_s;
        any_o = |req_i;
    end

endmodule

// File: rtl/uart_arbiter.sv
// UART ownership arbiter for four cores: round-robin grant, explicit release,
// inactivity timeout, and an owner switch only once the transmitter has drained.
module uart_arbiter
    import uart_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = UART_ARB_TIMEOUT,
    parameter int CNT_W          = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_CPU-1:0]     cpu_req,
    input  logic [N_CPU-1:0]     cpu_rel,
    input  logic                 uart_wr,
    input  logic                 uart_tx_busy,
    output logic [CPU_NUM_W-1:0] cpu_uart_num,
    output logic [N_CPU-1:0]     cpu_grant,
    output logic                 timeout_evt
);

    localparam logic             TO_EN    = 1'(TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e           state_q, state_d;
    logic [CPU_NUM_W-1:0] num_q, num_d;
    logic [N_CPU-1:0]     grant_q, grant_d;
    logic                 tevt_q, tevt_d;
    logic [CPU_NUM_W-1:0] rr_q, rr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [CPU_NUM_W-1:0] pick_idx_s;
    logic                 pick_any_s;
    logic                 owner_rel_s;
    logic                 owner_drop_s;
    logic                 to_hit_s;

    rr_pick4 u_pick (
        .req_i (cpu_req),
        .ptr_i (rr_q),
        .idx_o (pick_idx_s),
        .any_o (pick_any_s)
    );

    assign owner_rel_s  = cpu_rel[num_q];
    assign owner_drop_s = ~cpu_req[num_q];
    // A write in the would-be timeout cycle clears the count instead of expiring it.
    assign to_hit_s     = TO_EN & ~uart_wr & (cnt_q == CNT_LAST);

    // Next-state and output logic of the ownership FSM.
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        grant_d = grant_q;
        tevt_d  = 1'b0;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any_s) begin
                    num_d   = pick_idx_s;
                    state_d = ST_SWITCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SWITCH: begin
                grant_d = idx_to_onehot(num_q);
                state_d = ST_GRANT;
            end
            ST_GRANT: begin
                if (owner_rel_s || owner_drop_s || to_hit_s) begin
                    grant_d = 4'b0000;
                    rr_d    = num_q + 2'd1;
                    cnt_d   = {CNT_W{1'b0}};
                    tevt_d  = to_hit_s & ~(owner_rel_s | owner_drop_s);
                    state_d = ST_DRAIN;
                end else if (uart_wr) begin
                    cnt_d = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DRAIN: begin
                grant_d = 4'b0000;
                if (!uart_tx_busy) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                grant_d = 4'b0000;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any grant immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            num_q   <= {CPU_NUM_W{1'b0}};
            grant_q <= 4'b0000;
            tevt_q  <= 1'b0;
            rr_q    <= {CPU_NUM_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            grant_q <= grant_d;
            tevt_q  <= tevt_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cpu_uart_num = num_q;
    assign cpu_grant    = grant_q;
    assign timeout_evt  = tevt_q;

    uart_arbiter_chk u_chk (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_grant    (grant_q),
        .cpu_uart_num (num_q)
    );

endmodule
